arashi_mem_rd: RTL and testbench

Read-side engine for the arashi memory: it serves burst read requests from the cache and streams memory words back toward the cache over a valid/ready channel. It sits between the cache's fill logic and the memory array's synchronous read port, the opposite direction of the cache-to-memory write path. A 2-entry skid buffer absorbs the one-cycle memory read latency under cache backpressure without losing or duplicating words.

---
 rtl/arashi_pkg.sv | 10 +
 rtl/arashi_mem_rd_if.sv | 30 +++
 rtl/arashi_skid_fifo.sv | 54 +++++
 rtl/arashi_mem_rd.sv | 98 +++++++++
 tb/tb_arashi_mem_rd.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/arashi_pkg.sv
// Shared types and constants for the arashi memory read engine.
package arashi_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} arashi_rd_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/arashi_mem_rd_if.sv
// Request, memory read port and cache-side beat channel of the read engine.
interface arashi_mem_rd_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WIDTH   = 10,
    parameter int BURST_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [MEM_WIDTH-1:0]   req_addr;
    logic [BURST_WIDTH-1:0] req_len;
    logic                   mem_re;
    logic [MEM_WIDTH-1:0]   mem_raddr;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   mem2cache_valid;
    logic                   mem2cache_ready;
    logic [DATA_WIDTH-1:0]  mem2cache;
    logic                   mem2cache_last;

    // slave is the read engine; master is the cache plus memory array around it
    modport slave (
        input  req_valid, req_addr, req_len, mem_rdata, mem2cache_ready,
        output req_ready, mem_re, mem_raddr, mem2cache_valid, mem2cache, mem2cache_last
    );

    modport master (
        output req_valid, req_addr, req_len, mem_rdata, mem2cache_ready,
        input  req_ready, mem_re, mem_raddr, mem2cache_valid, mem2cache, mem2cache_last
    );

endinterface

// File: rtl/arashi_skid_fifo.sv
// Two-entry skid FIFO; head entry is presented combinationally, no push-to-pop bypass.
module arashi_skid_fifo
    import arashi_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [SKID_CNT_W-1:0] count,
    output logic                  empty,
    output logic                  full
);

    logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_q;
    logic [SKID_PTR_W-1:0] rd_q;
    logic [SKID_CNT_W-1:0] count_q;
    logic                  push_ok;
    logic                  pop_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == SKID_CNT_W'(SKID_DEPTH));
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        count   = count_q;
        dout    = mem_q[rd_q];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + SKID_CNT_W'(push_ok) - SKID_CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/arashi_mem_rd.sv
// Burst read engine: issues memory reads under skid-buffer credit and streams beats to the cache.
module arashi_mem_rd
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WIDTH   = 10,
    parameter int BURST_WIDTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    arashi_mem_rd_if.slave  bus,
    output logic            busy
);

    arashi_rd_state_t       state_q;
    logic [MEM_WIDTH-1:0]   addr_q;
    logic [BURST_WIDTH-1:0] cnt_q;
    logic                   inflight_q;
    logic                   last_q;

    logic [DATA_WIDTH:0]    fifo_dout;
    logic [SKID_CNT_W-1:0]  fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic [2:0]             occ;
    logic                   issue;
    logic                   drain_done;

    arashi_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({last_q, bus.mem_rdata}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        pop   = !fifo_empty && bus.mem2cache_ready;
        // occupancy after this edge: FIFO entries plus the word returning next cycle
        occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == ISSUE) && (occ < 3'd2);
        // leave DRAIN on the edge that pops the final beat
        drain_done = !inflight_q && (fifo_empty || (pop && !fifo_full));
    end

    assign bus.req_ready       = (state_q == IDLE);
    assign bus.mem_re          = issue;
    assign bus.mem_raddr       = addr_q;
    assign bus.mem2cache_valid = !fifo_empty;
    assign bus.mem2cache       = fifo_dout[DATA_WIDTH-1:0];
    assign bus.mem2cache_last  = fifo_dout[DATA_WIDTH];
    assign busy                = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            last_q     <= issue && (cnt_q == '0);
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        cnt_q   <= bus.req_len;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arashi_mem_rd.sv
// Directed bench for arashi_mem_rd with a one-cycle-latency memory model.
module tb_arashi_mem_rd;

    logic clk;
    logic rstn;
    logic busy;

    int n_assert;
    int n_fail;

    logic [31:0] mem [1024];

    // per-cycle expectations for a burst, relative to the request base address
    int exp_re [14];
    int exp_bt [14];
    bit rdy    [14];

    arashi_mem_rd_if #(.DATA_WIDTH(32), .MEM_WIDTH(10), .BURST_WIDTH(4)) bus ();

    arashi_mem_rd #(
        .DATA_WIDTH (32),
        .MEM_WIDTH  (10),
        .BURST_WIDTH(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr];
    end

    function automatic logic [31:0] word(input int a);
        return 32'hA5C3_0000 + 32'(a & 1023);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, ".mem_re"}, 64'(bus.mem_re), 64'd0);
        chk({tag, ".mem_raddr"}, 64'(bus.mem_raddr), 64'd0);
        chk({tag, ".valid"}, 64'(bus.mem2cache_valid), 64'd0);
        chk({tag, ".data"}, 64'(bus.mem2cache), 64'd0);
        chk({tag, ".last"}, 64'(bus.mem2cache_last), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run(input string tag, input int base, input int len, input int ncyc);
        string t;
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'(base);
        bus.req_len   = 4'(len);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            bus.mem2cache_ready = rdy[c];
            #1;
            t = $sformatf("%s.c%0d", tag, c);
            if (c == 0) begin
                chk({t, ".busy"}, 64'(busy), 64'd1);
                chk({t, ".req_ready"}, 64'(bus.req_ready), 64'd0);
            end
            chk({t, ".mem_re"}, 64'(bus.mem_re), 64'(exp_re[c] >= 0));
            if (exp_re[c] >= 0)
                chk({t, ".mem_raddr"}, 64'(bus.mem_raddr), 64'((base + exp_re[c]) & 1023));
            chk({t, ".valid"}, 64'(bus.mem2cache_valid), 64'(exp_bt[c] >= 0));
            if (exp_bt[c] >= 0) begin
                chk({t, ".data"}, 64'(bus.mem2cache), 64'(word(base + exp_bt[c])));
                chk({t, ".last"}, 64'(bus.mem2cache_last), 64'(exp_bt[c] == len));
            end
        end
        @(posedge clk); #2;
        chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
        chk({tag, ".idle_req_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5C3_0000 + 32'(i);
        rstn                = 1'b0;
        bus.req_valid       = 1'b0;
        bus.req_addr        = '0;
        bus.req_len         = '0;
        bus.mem2cache_ready = 1'b1;
        bus.mem_rdata       = '0;
        #3;
        chk_reset_vals("reset");
        #9 rstn = 1'b1;

        // single beat at address 5
        exp_re = '{0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        exp_bt = '{-1, -1, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        rdy    = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        run("single", 5, 0, 3);

        // 4-beat burst, back-to-back
        exp_re = '{0, 1, 2, 3, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        exp_bt = '{-1, -1, 0, 1, 2, 3, -1, -1, -1, -1, -1, -1, -1, -1};
        run("burst4", 16, 3, 6);

        // address wrap 1022,1023,0,1
        run("wrap", 1022, 3, 6);

        // 8 beats, ready low for three cycles while beat 2 is offered
        exp_re = '{0, 1, 2, 3, -1, -1, -1, 4, 5, 6, 7, -1, -1, -1};
        exp_bt = '{-1, -1, 0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, -1};
        rdy    = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        run("bp", 100, 7, 13);
        bus.mem2cache_ready = 1'b1;

        // request held high during a 2-beat burst with a different address
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'd200;
        bus.req_len   = 4'd1;
        @(posedge clk); #1;
        bus.req_addr  = 10'd300;
        bus.req_len   = 4'd0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            #1;
            chk($sformatf("hold.c%0d.req_ready", c), 64'(bus.req_ready), 64'd0);
            if (c < 2) chk($sformatf("hold.c%0d.raddr", c), 64'(bus.mem_raddr), 64'(200 + c));
            if (c >= 2) chk($sformatf("hold.c%0d.data", c), 64'(bus.mem2cache), 64'(word(200 + c - 2)));
        end
        chk("hold.c3.last", 64'(bus.mem2cache_last), 64'd1);
        @(posedge clk); #2;
        chk("hold.c4.req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #1;
        chk("hold.c5.mem_re", 64'(bus.mem_re), 64'd1);
        chk("hold.c5.raddr", 64'(bus.mem_raddr), 64'd300);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("hold.c7.valid", 64'(bus.mem2cache_valid), 64'd1);
        chk("hold.c7.data", 64'(bus.mem2cache), 64'(word(300)));
        chk("hold.c7.last", 64'(bus.mem2cache_last), 64'd1);
        @(posedge clk); #2;
        chk("hold.c8.busy", 64'(busy), 64'd0);

        // reset asserted during beat 3 of an 8-beat burst
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'd400;
        bus.req_len   = 4'd7;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
        end
        #1;
        chk("rst.beat3.valid", 64'(bus.mem2cache_valid), 64'd1);
        chk("rst.beat3.data", 64'(bus.mem2cache), 64'(word(402)));
        #1 rstn = 1'b0;
        #1;
        chk_reset_vals("rst.async");
        @(posedge clk);
        @(posedge clk); #3;
        rstn = 1'b1;
        #1;
        chk("rst.release.req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst.release.busy", 64'(busy), 64'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #2;
            chk($sformatf("rst.after%0d.valid", c), 64'(bus.mem2cache_valid), 64'd0);
            chk($sformatf("rst.after%0d.mem_re", c), 64'(bus.mem_re), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
